// File: rtl/rrf_alloc_ctrl_pkg.sv
// Shared constants, types and the tag-wrap helper for the RRF allocation
// controller. Tag 0 is reserved as "no rename"; usable tags are 1..RRF_NUM-1.
package rrf_alloc_ctrl_pkg;

  localparam int RRF_NUM = 64;
  localparam int RRF_SEL = 6;

  typedef logic [RRF_SEL-1:0] rrf_tag_t;
  typedef logic [RRF_SEL:0]   rrf_cnt_t;

  localparam rrf_cnt_t RRF_LAST  = rrf_cnt_t'(RRF_NUM - 1);
  localparam rrf_tag_t RRF_FIRST = rrf_tag_t'(1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_STALL   = 2'd1,
    ST_RECOVER = 2'd2
  } rrf_state_e;

  // Advance a tag by 0..2 (3 tolerated) over 1..RRF_NUM-1, skipping tag 0.
  function automatic rrf_tag_t rrf_wrap(input rrf_tag_t ptr, input logic [1:0] inc);
    rrf_cnt_t sum;
    sum = {1'b0, ptr} + {{(RRF_SEL-1){1'b0}}, inc};
    if (sum > RRF_LAST) sum = sum - RRF_LAST;
    return sum[RRF_SEL-1:0];
  endfunction

endpackage

// File: rtl/rrf_alloc_ctrl_if.sv
// Dispatch / commit / flush bundle between DP, COM and the RRF allocator.
// Handshake: a rename group transfers on a cycle where dp_valid_i and
// dp_ready_o are both high; dp_ready_o may depend combinationally on
// com_num_i and flush_i but never on dp_valid_i, and the tags on
// alloc_tag0_o/alloc_tag1_o are meaningful only on a transfer cycle.
interface rrf_alloc_ctrl_if;
  import rrf_alloc_ctrl_pkg::*;

  logic        dp_valid_i;
  logic [1:0]  dp_req_num_i;
  logic        dp_ready_o;
  rrf_tag_t    alloc_tag0_o;
  rrf_tag_t    alloc_tag1_o;
  logic [1:0]  com_num_i;
  logic        flush_i;
  rrf_cnt_t    freenum_o;
  rrf_tag_t    rrfptr_o;
  rrf_tag_t    comptr_o;
  logic        nextrrfcyc_o;
  logic        stall_dp_o;
  logic [31:0] perf_stall_cnt_o;
  logic [31:0] perf_alloc_cnt_o;
  rrf_state_e  state_dbg;

  modport master (
    output dp_valid_i, dp_req_num_i, com_num_i, flush_i,
    input  dp_ready_o, alloc_tag0_o, alloc_tag1_o, freenum_o, rrfptr_o,
           comptr_o, nextrrfcyc_o, stall_dp_o, perf_stall_cnt_o,
           perf_alloc_cnt_o, state_dbg
  );

  modport slave (
    input  dp_valid_i, dp_req_num_i, com_num_i, flush_i,
    output dp_ready_o, alloc_tag0_o, alloc_tag1_o, freenum_o, rrfptr_o,
           comptr_o, nextrrfcyc_o, stall_dp_o, perf_stall_cnt_o,
           perf_alloc_cnt_o, state_dbg
  );

endinterface

// File: rtl/rrf_ptr_wrap.sv
// Combinational add-with-wrap over tags 1..RRF_NUM-1, increment 0..2.
module rrf_ptr_wrap
  import rrf_alloc_ctrl_pkg::*;
(
  input  rrf_tag_t   ptr_i,
  input  logic [1:0] inc_i,
  output rrf_tag_t   ptr_o
);

  assign ptr_o = rrf_wrap(ptr_i, inc_i);

endmodule

// File: rtl/rrf_alloc_ctrl.sv
// RRF allocation controller: all-or-nothing grant of up to two rename tags per
// cycle, commit crediting, and free-list restore on flush.
// Optional feature macro: RRF_ALLOC_PERF_EN builds the saturating stall and
// allocation performance counters; otherwise both counter ports read 0.
module rrf_alloc_ctrl
  import rrf_alloc_ctrl_pkg::*;
(
  input  logic            clk_i,
  input  logic            reset_n_i,
  rrf_alloc_ctrl_if.slave bus
);

  rrf_state_e state_q, state_d;
  rrf_cnt_t   freenum_q, freenum_d, avail, free_sum, inflight;
  rrf_tag_t   rrfptr_q, rrfptr_d, rrfptr_inc, tag1, comptr_q, comptr_d;
  logic       nextrrfcyc_q, dp_ready, grant;
  logic [1:0] grant_num;

  rrf_ptr_wrap u_wrap_rrf  (.ptr_i(rrfptr_q), .inc_i(grant_num),     .ptr_o(rrfptr_inc));
  rrf_ptr_wrap u_wrap_tag1 (.ptr_i(rrfptr_q), .inc_i(2'd1),          .ptr_o(tag1));
  rrf_ptr_wrap u_wrap_com  (.ptr_i(comptr_q), .inc_i(bus.com_num_i), .ptr_o(comptr_d));

  // Same-cycle commits are credited before the grant decision.
  assign avail     = freenum_q + {{(RRF_SEL-1){1'b0}}, bus.com_num_i};
  assign dp_ready  = (state_q != ST_RECOVER) && !bus.flush_i &&
                     (avail >= {{(RRF_SEL-1){1'b0}}, bus.dp_req_num_i});
  assign grant     = bus.dp_valid_i && dp_ready;
  assign grant_num = grant ? bus.dp_req_num_i : 2'd0;
  assign free_sum  = avail - {{(RRF_SEL-1){1'b0}}, grant_num};
  assign freenum_d = (bus.flush_i || (free_sum > RRF_LAST)) ? RRF_LAST : free_sum;
  // A flush rewinds allocation to just past whatever commits this cycle.
  assign rrfptr_d  = bus.flush_i ? comptr_d : rrfptr_inc;
  assign inflight  = RRF_LAST - freenum_q;

  // Next-state logic: flush dominates, RECOVER always lasts one cycle.
  always_comb begin
    state_d = state_q;
    if (bus.flush_i) begin
      state_d = ST_RECOVER;
    end else begin
      case (state_q)
        ST_RUN:   if (bus.dp_valid_i && !dp_ready) state_d = ST_STALL;
        ST_STALL: if (grant) state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  // State, pointers, free count and wrap pulse.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= ST_RUN;
      freenum_q    <= RRF_LAST;
      rrfptr_q     <= RRF_FIRST;
      comptr_q     <= RRF_FIRST;
      nextrrfcyc_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      freenum_q    <= freenum_d;
      rrfptr_q     <= rrfptr_d;
      comptr_q     <= comptr_d;
      // With increments of at most 2 the pointer only moves backwards on a wrap.
      nextrrfcyc_q <= (grant_num != 2'd0) && (rrfptr_inc < rrfptr_q);
    end
  end

  assign bus.dp_ready_o   = dp_ready;
  assign bus.alloc_tag0_o = rrfptr_q;
  assign bus.alloc_tag1_o = tag1;
  assign bus.freenum_o    = freenum_q;
  assign bus.rrfptr_o     = rrfptr_q;
  assign bus.comptr_o     = comptr_q;
  assign bus.nextrrfcyc_o = nextrrfcyc_q;
  assign bus.stall_dp_o   = (state_q == ST_STALL);
  assign bus.state_dbg    = state_q;

`ifdef RRF_ALLOC_PERF_EN
  logic [31:0] stall_cnt_q, alloc_cnt_q;
  logic [32:0] alloc_sum;

  assign alloc_sum = {1'b0, alloc_cnt_q} + {31'd0, grant_num};

  // Saturating performance counters, cleared only by reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stall_cnt_q <= '0;
      alloc_cnt_q <= '0;
    end else begin
      if ((state_q == ST_STALL) && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      alloc_cnt_q <= alloc_sum[32] ? '1 : alloc_sum[31:0];
    end
  end

  assign bus.perf_stall_cnt_o = stall_cnt_q;
  assign bus.perf_alloc_cnt_o = alloc_cnt_q;
`else
  assign bus.perf_stall_cnt_o = '0;
  assign bus.perf_alloc_cnt_o = '0;
`endif

  a_req_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    bus.dp_valid_i |-> (bus.dp_req_num_i != 2'd3));
  a_com_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    ({{(RRF_SEL-1){1'b0}}, bus.com_num_i} <= inflight));

endmodule

// File: doc/rrf_alloc_ctrl.md
# rrf_alloc_ctrl

Dispatch-side controller for the rename register file (RRF). Per cycle it accepts up to two destination-rename requests from DP, grants them all-or-nothing against the free-entry count, and returns the allocated RRF tags. It tracks the allocation and commit pointers, credits commits from COM, and restores the free list on a pipeline flush. It sits between the decode/dispatch stage and the RRF, and is the only writer of the RRF allocation state.

## Interface
- RRF_NUM, 64: total RRF entries; tag 0 reserved as "no rename", usable tags 1..RRF_NUM-1
- RRF_SEL, 6: tag width, log2(RRF_NUM)
- clk_i  in  1  clock, rising edge
- reset_n_i  in  1  reset, asynchronous assert, active-low
- dp_valid_i  in  1  DP presents a rename request group this cycle
- dp_req_num_i  in  2  destinations requested, 0..2; 3 is illegal
- dp_ready_o  out  1  group granted when dp_valid_i && dp_ready_o
- alloc_tag0_o  out  RRF_SEL  tag for first destination
- alloc_tag1_o  out  RRF_SEL  tag for second destination
- com_num_i  in  2  entries retired by COM this cycle, 0..2
- flush_i  in  1  mispredict/exception flush; discard all uncommitted allocations
- freenum_o  out  RRF_SEL+1  free usable entries
- rrfptr_o  out  RRF_SEL  next tag to allocate
- comptr_o  out  RRF_SEL  oldest uncommitted tag
- nextrrfcyc_o  out  1  one-cycle pulse: last grant wrapped rrfptr_o
- stall_dp_o  out  1  DP stalled for lack of RRF entries
- perf_stall_cnt_o  out  32  cycles in STALL (see Configuration)
- perf_alloc_cnt_o  out  32  total tags allocated (see Configuration)

## Operation
- States: RUN, STALL, RECOVER. Reset: RUN, rrfptr_o=1, comptr_o=1, freenum_o=RRF_NUM-1, nextrrfcyc_o=0, stall_dp_o=0, perf counters 0.
- Wrap rule: increment over tags 1..RRF_NUM-1; RRF_NUM-1 + 1 -> 1, RRF_NUM-1 + 2 -> 2. Tag 0 never produced.
- alloc_tag0_o = rrfptr_o; alloc_tag1_o = wrap(rrfptr_o+1). Valid only when granted.
- dp_ready_o = state!=RECOVER && !flush_i && (freenum_o + com_num_i >= dp_req_num_i). dp_req_num_i=0 with dp_valid_i is always granted (no-op).
- Grant g = dp_valid_i && dp_ready_o ? dp_req_num_i : 0. Next freenum_o = freenum_o + com_num_i - g; rrfptr_o += g (wrapped); comptr_o += com_num_i (wrapped). Arithmetic in RRF_SEL+1 bits; freenum_o never exceeds RRF_NUM-1.
- nextrrfcyc_o registered: 1 iff this cycle's grant crossed RRF_NUM-1 -> 1.
- RUN -> STALL: dp_valid_i && !dp_ready_o && !flush_i. STALL -> RUN: cycle of grant. stall_dp_o = (state==STALL) registered.
- Flush (any state, highest priority): no grant that cycle; comptr_o still advances by com_num_i; next rrfptr_o = next comptr_o; freenum_o = RRF_NUM-1; state -> RECOVER. RECOVER lasts exactly one cycle (dp_ready_o=0), then RUN. Flush in RECOVER re-enters RECOVER.
- Protocol violations (assertions, not handled): dp_req_num_i==3; com_num_i exceeding in-flight count (RRF_NUM-1 - freenum_o).

## Timing
- dp_ready_o and alloc tags combinational from registers plus com_num_i/flush_i; same-cycle commits may fund same-cycle grants.
- All state and counters update on the grant edge; new rrfptr_o visible next cycle.
- Flush -> first possible grant: 2 cycles later (flush cycle, RECOVER, grant in RUN).
- reset_n_i low mid-operation: all outputs return to reset values immediately, asynchronously.

## Configuration
- RRF_ALLOC_PERF_EN defined: perf_stall_cnt_o increments each cycle in STALL; perf_alloc_cnt_o adds g each cycle; both saturate at 2^32-1, cleared only by reset.
- Undefined: counters not built; both ports tied to 0.

## Structure
- RRF_NUM, RRF_SEL, tag-wrap helper and state encoding in the shared consts package; RRF_SEL width macros carry explicit widths.
- One sub-module: rrf_ptr_wrap (combinational add-with-wrap over 1..RRF_NUM-1, increment 0..2), instanced for rrfptr, tag1 and comptr.

## Test plan
- Reset, then dp_valid_i=1, dp_req_num_i=2 -> dp_ready_o=1, tags 1 and 2; next cycle rrfptr_o=3, freenum_o=61.
- Allocate 2/cycle until freenum_o=1, request 2 with com_num_i=0 -> dp_ready_o=0, stall_dp_o=1 next cycle; raise com_num_i=1 -> grant same cycle, freenum_o=0.
- rrfptr_o=63, request 2 (commits available) -> tags 63 and 1, rrfptr_o=2, nextrrfcyc_o pulses one cycle.
- 10 allocated, comptr_o=1, flush_i with com_num_i=2 -> no grant; next: comptr_o=3, rrfptr_o=3, freenum_o=63, RECOVER; grant resumes the following cycle with tag 3.
- Flush and dp_valid_i in same cycle -> dp_ready_o=0, rrfptr_o unaffected by request.
- With RRF_ALLOC_PERF_EN: 5 stall cycles and 12 grants of 1 -> perf_stall_cnt_o=5, perf_alloc_cnt_o=12; without: both read 0.
